pkt_data_buffer: RTL and testbench

PKT_DATA_BUFFER -- requirements
Module: pkt_data_buffer

---
 rtl/pkt_data_buffer.sv | 100 ++++++++++
 tb/tb_pkt_data_buffer.sv | 387 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pkt_data_buffer.sv
// Packet retransmit buffer: FIFO with a commit pointer so that read
// data stays held until the packet is acked (commit) or replayed (rewind).
module pkt_data_buffer #(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 64,
  parameter int AF_THRESH = DEPTH - 4
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    store_data,
  input  logic [DATA_W-1:0]       wdata,
  input  logic                    get_data,
  output logic [DATA_W-1:0]       rdata,
  input  logic                    commit,
  input  logic                    rewind,
  input  logic                    clear,
  output logic [$clog2(DEPTH):0]  buffer_occupancy,
  output logic [$clog2(DEPTH):0]  pending_count,
  output logic                    full,
  output logic                    empty,
  output logic                    almost_full,
  output logic                    overflow_err,
  output logic                    underflow_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic [PW-1:0] cptr;
  logic [PW-1:0] used;

  logic do_store;
  logic do_get;
  logic do_commit;
  logic do_rewind;

  assign buffer_occupancy = wptr - rptr;
  assign pending_count    = rptr - cptr;
  assign used             = wptr - cptr;

  assign full        = (used == PW'(DEPTH));
  assign empty       = (buffer_occupancy == '0);
  assign almost_full = (used >= PW'(AF_THRESH));

  // rewind outranks the read side; the write side only yields to clear
  assign do_rewind = rewind & ~clear;
  assign do_get    = get_data & ~empty & ~clear & ~rewind;
  assign do_commit = commit & ~clear & ~rewind;
  assign do_store  = store_data & ~full & ~clear;

  always_ff @(posedge clk) begin
    if (do_store) begin
      mem[wptr[AW-1:0]] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wptr          <= '0;
      rptr          <= '0;
      cptr          <= '0;
      rdata         <= '0;
      overflow_err  <= 1'b0;
      underflow_err <= 1'b0;
    end else if (clear) begin
      wptr          <= '0;
      rptr          <= '0;
      cptr          <= '0;
      rdata         <= '0;
      overflow_err  <= 1'b0;
      underflow_err <= 1'b0;
    end else begin
      if (do_store) begin
        wptr <= wptr + PW'(1);
      end
      unique case (1'b1)
        do_rewind: rptr <= cptr;
        do_get: begin
          rptr  <= rptr + PW'(1);
          rdata <= mem[rptr[AW-1:0]];
        end
        default: ;
      endcase
      if (do_commit) begin
        cptr <= rptr;
      end
      if (store_data && full) begin
        overflow_err <= 1'b1;
      end
      if (get_data && empty && !rewind) begin
        underflow_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pkt_data_buffer.sv
// Self-checking bench for pkt_data_buffer: queue model of stored data
// plus a scoreboard of expected read data.
module tb_pkt_data_buffer;

  localparam int DW    = 8;
  localparam int DEPTH = 64;

  logic          clk;
  logic          n_rst;
  logic          store_data;
  logic [DW-1:0] wdata;
  logic          get_data;
  logic [DW-1:0] rdata;
  logic          commit;
  logic          rewind;
  logic          clear;
  logic [6:0]    buffer_occupancy;
  logic [6:0]    pending_count;
  logic          full;
  logic          empty;
  logic          almost_full;
  logic          overflow_err;
  logic          underflow_err;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] mq[$];
  logic [DW-1:0] exp_q[$];
  int            rd = 0;
  logic [DW-1:0] m_rdata = '0;
  logic          m_ovf = 1'b0;
  logic          m_unf = 1'b0;

  pkt_data_buffer #(
    .DATA_W(DW),
    .DEPTH(DEPTH),
    .AF_THRESH(DEPTH - 4)
  ) dut (
    .clk(clk),
    .n_rst(n_rst),
    .store_data(store_data),
    .wdata(wdata),
    .get_data(get_data),
    .rdata(rdata),
    .commit(commit),
    .rewind(rewind),
    .clear(clear),
    .buffer_occupancy(buffer_occupancy),
    .pending_count(pending_count),
    .full(full),
    .empty(empty),
    .almost_full(almost_full),
    .overflow_err(overflow_err),
    .underflow_err(underflow_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input logic st, input logic [DW-1:0] wd,
                      input logic gt, input logic cm,
                      input logic rw, input logic cl);
    logic pf;
    logic pe;
    int   ro;
    store_data = st;
    wdata      = wd;
    get_data   = gt;
    commit     = cm;
    rewind     = rw;
    clear      = cl;
    if (cl) begin
      mq.delete();
      rd      = 0;
      m_rdata = '0;
      m_ovf   = 1'b0;
      m_unf   = 1'b0;
    end else begin
      pf = (mq.size() == DEPTH);
      pe = (rd == mq.size());
      ro = rd;
      if (rw) begin
        rd = 0;
      end else begin
        if (gt && pe) m_unf = 1'b1;
        if (gt && !pe) begin
          m_rdata = mq[rd];
          exp_q.push_back(mq[rd]);
          rd++;
        end
        if (cm) begin
          repeat (ro) void'(mq.pop_front());
          rd -= ro;
        end
      end
      if (st) begin
        if (pf) m_ovf = 1'b1;
        else mq.push_back(wd);
      end
    end
    @(posedge clk);
    #1;
    store_data = 1'b0;
    get_data   = 1'b0;
    commit     = 1'b0;
    rewind     = 1'b0;
    clear      = 1'b0;
  endtask

  task automatic test_reset();
    n_rst = 1'b1;
    #3 n_rst = 1'b0;
    #1;
    checks++;
    if (buffer_occupancy !== 7'd0 || pending_count !== 7'd0) begin
      errors++;
      $display("FAIL reset_counts occ=%0d pend=%0d want 0/0",
               buffer_occupancy, pending_count);
    end
    checks++;
    if ({empty, full, almost_full} !== 3'b100) begin
      errors++;
      $display("FAIL reset_flags e/f/af=%b want 100",
               {empty, full, almost_full});
    end
    checks++;
    if ({overflow_err, underflow_err} !== 2'b00 || rdata !== 8'h00) begin
      errors++;
      $display("FAIL reset_err ovf/unf=%b rdata=%h want 00/00",
               {overflow_err, underflow_err}, rdata);
    end
    @(posedge clk);
    #1 n_rst = 1'b1;
  endtask

  task automatic test_fill();
    step(0, 0, 0, 0, 0, 1);
    for (int i = 0; i < DEPTH; i++) begin
      step(1, DW'(i), 0, 0, 0, 0);
      if (i == 58) begin
        checks++;
        if (almost_full !== 1'b0) begin
          errors++;
          $display("FAIL af_below got=%b want 0", almost_full);
        end
      end
      if (i == 59) begin
        checks++;
        if (almost_full !== 1'b1) begin
          errors++;
          $display("FAIL af_at got=%b want 1", almost_full);
        end
      end
    end
    checks++;
    if (buffer_occupancy !== 7'd64 || full !== 1'b1 || almost_full !== 1'b1) begin
      errors++;
      $display("FAIL fill occ=%0d f=%b af=%b want 64/1/1",
               buffer_occupancy, full, almost_full);
    end
    step(1, 8'hEE, 0, 0, 0, 0);
    checks++;
    if (overflow_err !== 1'b1 || buffer_occupancy !== 7'd64) begin
      errors++;
      $display("FAIL overflow ovf=%b occ=%0d want 1/64",
               overflow_err, buffer_occupancy);
    end
  endtask

  task automatic test_drain_commit();
    logic [DW-1:0] e;
    for (int i = 0; i < DEPTH; i++) begin
      step(0, 0, 1, 0, 0, 0);
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL drain_sb empty at %0d", i);
      end else begin
        e = exp_q.pop_front();
        if (rdata !== e || e !== DW'(i)) begin
          errors++;
          $display("FAIL drain_data[%0d] got=%h want %h", i, rdata, DW'(i));
        end
      end
    end
    checks++;
    if (empty !== 1'b1 || full !== 1'b1 || pending_count !== 7'd64) begin
      errors++;
      $display("FAIL drained e=%b f=%b pend=%0d want 1/1/64",
               empty, full, pending_count);
    end
    step(0, 0, 0, 1, 0, 0);
    checks++;
    if (full !== 1'b0 || pending_count !== 7'd0 ||
        buffer_occupancy !== 7'd0 || almost_full !== 1'b0) begin
      errors++;
      $display("FAIL commit f=%b pend=%0d occ=%0d af=%b want 0/0/0/0",
               full, pending_count, buffer_occupancy, almost_full);
    end
  endtask

  task automatic test_rewind();
    logic [DW-1:0] e;
    step(0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 10; i++) step(1, DW'(i), 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 1, 0, 0, 0);
      e = exp_q.pop_front();
      checks++;
      if (rdata !== e || e !== DW'(i)) begin
        errors++;
        $display("FAIL rew_data[%0d] got=%h want %h", i, rdata, DW'(i));
      end
    end
    step(0, 0, 0, 0, 1, 0);
    checks++;
    if (buffer_occupancy !== 7'd10 || pending_count !== 7'd0) begin
      errors++;
      $display("FAIL rewind occ=%0d pend=%0d want 10/0",
               buffer_occupancy, pending_count);
    end
    step(0, 0, 1, 0, 0, 0);
    e = exp_q.pop_front();
    checks++;
    if (rdata !== e || e !== 8'h00) begin
      errors++;
      $display("FAIL rew_replay got=%h want 00", rdata);
    end
  endtask

  task automatic test_rewind_get();
    logic [DW-1:0] e;
    step(0, 0, 1, 0, 0, 0);
    e = exp_q.pop_front();
    step(0, 0, 1, 0, 0, 0);
    e = exp_q.pop_front();
    checks++;
    if (rdata !== e) begin
      errors++;
      $display("FAIL rg_pre got=%h want %h", rdata, e);
    end
    step(1, 8'h77, 1, 1, 1, 0);
    checks++;
    if (pending_count !== 7'd0 || rdata !== m_rdata || underflow_err !== 1'b0) begin
      errors++;
      $display("FAIL rew_get pend=%0d rdata=%h unf=%b want 0/%h/0",
               pending_count, rdata, underflow_err, m_rdata);
    end
    checks++;
    if (buffer_occupancy !== 7'(mq.size() - rd) || exp_q.size() != 0) begin
      errors++;
      $display("FAIL rew_store occ=%0d want %0d",
               buffer_occupancy, mq.size() - rd);
    end
  endtask

  task automatic test_underflow();
    logic [DW-1:0] e;
    step(0, 0, 0, 0, 0, 1);
    step(1, 8'hA5, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0);
    e = exp_q.pop_front();
    step(0, 0, 0, 1, 0, 0);
    step(0, 0, 1, 0, 0, 0);
    checks++;
    if (underflow_err !== 1'b1 || rdata !== e || e !== 8'hA5) begin
      errors++;
      $display("FAIL underflow unf=%b rdata=%h want 1/a5", underflow_err, rdata);
    end
    step(0, 0, 0, 0, 0, 1);
    checks++;
    if (underflow_err !== 1'b0 || buffer_occupancy !== 7'd0 ||
        pending_count !== 7'd0 || rdata !== 8'h00 || empty !== 1'b1) begin
      errors++;
      $display("FAIL clear unf=%b occ=%0d pend=%0d rdata=%h",
               underflow_err, buffer_occupancy, pending_count, rdata);
    end
  endtask

  task automatic test_wrap();
    logic [DW-1:0] e;
    for (int it = 0; it < 3; it++) begin
      for (int k = 0; k < 40; k++) step(1, DW'(it * 40 + k), 0, 0, 0, 0);
      for (int k = 0; k < 40; k++) begin
        step(0, 0, 1, 0, 0, 0);
        e = exp_q.pop_front();
        checks++;
        if (rdata !== e || e !== DW'(it * 40 + k)) begin
          errors++;
          $display("FAIL wrap[%0d][%0d] got=%h want %h",
                   it, k, rdata, DW'(it * 40 + k));
        end
      end
      step(0, 0, 0, 1, 0, 0);
      checks++;
      if (buffer_occupancy !== 7'd0 || pending_count !== 7'd0 || full !== 1'b0) begin
        errors++;
        $display("FAIL wrap_end[%0d] occ=%0d pend=%0d", it,
                 buffer_occupancy, pending_count);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] e;
    step(1, 8'h10, 0, 0, 0, 0);
    step(1, 8'h11, 0, 0, 0, 0);
    for (int k = 0; k < 6; k++) begin
      step(1, DW'(8'h20 + k), 1, 0, 0, 0);
      e = exp_q.pop_front();
      checks++;
      if (rdata !== e || buffer_occupancy !== 7'd2) begin
        errors++;
        $display("FAIL b2b[%0d] rdata=%h occ=%0d want %h/2",
                 k, rdata, buffer_occupancy, e);
      end
    end
    checks++;
    if (pending_count !== 7'd6 || overflow_err !== m_ovf) begin
      errors++;
      $display("FAIL b2b_pend pend=%0d ovf=%b want 6/%b",
               pending_count, overflow_err, m_ovf);
    end
  endtask

  task automatic test_reset_mid();
    logic [DW-1:0] e;
    step(1, 8'h55, 0, 0, 0, 0);
    store_data = 1'b1;
    get_data   = 1'b1;
    wdata      = 8'h66;
    #2 n_rst = 1'b0;
    #1;
    checks++;
    if (buffer_occupancy !== 7'd0 || pending_count !== 7'd0 ||
        empty !== 1'b1 || rdata !== 8'h00 || overflow_err !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset occ=%0d pend=%0d e=%b rdata=%h",
               buffer_occupancy, pending_count, empty, rdata);
    end
    store_data = 1'b0;
    get_data   = 1'b0;
    #4 n_rst = 1'b1;
    mq.delete();
    exp_q.delete();
    rd      = 0;
    m_rdata = '0;
    m_ovf   = 1'b0;
    m_unf   = 1'b0;
    step(0, 0, 0, 0, 0, 0);
    checks++;
    if (empty !== 1'b1 || buffer_occupancy !== 7'd0) begin
      errors++;
      $display("FAIL post_reset e=%b occ=%0d want 1/0", empty, buffer_occupancy);
    end
    step(1, 8'h3C, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0);
    e = exp_q.pop_front();
    checks++;
    if (rdata !== e || e !== 8'h3C) begin
      errors++;
      $display("FAIL post_reset_rd got=%h want 3c", rdata);
    end
  endtask

  initial begin
    store_data = 1'b0;
    wdata      = '0;
    get_data   = 1'b0;
    commit     = 1'b0;
    rewind     = 1'b0;
    clear      = 1'b0;
    test_reset();
    test_fill();
    test_drain_commit();
    test_rewind();
    test_rewind_get();
    test_underflow();
    test_wrap();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
